// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate recursive multiplier: mode encoding,
// leaf geometry and the per-leaf approximation policy.
package approx_mult_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_LOW   = 2'd1,
    MODE_ALL   = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  localparam int unsigned LEAF_W = 4;
  localparam int unsigned LEAF_P = 2 * LEAF_W;

  // Reserved mode behaves as exact.
  function automatic mode_e norm_mode(input logic [1:0] m);
    mode_e r;
    r = mode_e'(m);
    if (r == MODE_RSVD) r = MODE_EXACT;
    return r;
  endfunction

  // LOW approximates only leaves whose weight lies in the lower half of the
  // operand width, i.e. those that cannot touch the upper product bits much.
  function automatic logic leaf_approx_en(input int unsigned i, input int unsigned j,
                                          input mode_e mode, input int unsigned width);
    logic en;
    en = 1'b0;
    unique case (mode)
      MODE_ALL: en = 1'b1;
      MODE_LOW: en = (LEAF_W * (i + j)) < (width / 2);
      default:  en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/approx_recursive_mult_pipe_leaf.sv
// 4x4 leaf multiplier: exact product or the approximate compressor tree,
// selected by approx_en. Purely combinational.
module approx_mult4x4_leaf (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       approx_en,
  output logic [7:0] p
);

  logic [3:0][3:0] pp;
  logic [7:0]      p_exact;
  logic [7:0]      p_apx;
  logic s1, c1, p20, g20, s2, c2, g3, p21, p30, s3, c3;
  logic p31, g31, s4, c4, s5, c5, s6, c6;

  // Partial products and the approximate column reduction.
  always_comb begin
    for (int unsigned x = 0; x < 4; x++) begin
      for (int unsigned y = 0; y < 4; y++) begin
        pp[x][y] = a[x] & b[y];
      end
    end
    p_exact = {4'b0000, a} * {4'b0000, b};

    s1  = pp[0][1] ^ pp[1][0];
    c1  = pp[0][1] & pp[1][0];
    p20 = pp[2][0] | pp[0][2];
    g20 = pp[2][0] & pp[0][2];
    s2  = p20 | pp[1][1];
    c2  = g20 | c1;
    g3  = (pp[3][0] & pp[0][3]) | (pp[2][1] & pp[1][2]);
    p21 = pp[2][1] | pp[1][2];
    p30 = pp[3][0] | pp[0][3];
    s3  = c2 | p21 | p30;
    c3  = (c2 & g3) | (p21 & p30);
    p31 = pp[3][1] | pp[1][3];
    g31 = pp[3][1] & pp[1][3];
    s4  = p31 | pp[2][2];
    c4  = g31 | (pp[2][2] & c3);
    s5  = pp[3][2] ^ pp[2][3] ^ c4;
    c5  = (pp[3][2] & pp[2][3]) | (c4 & (pp[3][2] ^ pp[2][3]));
    s6  = pp[3][3] ^ c5;
    c6  = pp[3][3] & c5;
    p_apx = {c6, s6, s5, s4, s3, s2, s1, pp[0][0]};

    p = approx_en ? p_apx : p_exact;
  end

endmodule

// File: rtl/approx_recursive_mult_pipe.sv
// Three-stage pipelined recursive multiplier built from a grid of 4x4 leaves.
// S1 registers operands, S2 registers leaf products, S3 registers the
// shifted sum. A single advance signal stalls the whole pipe on backpressure.
module approx_recursive_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic [1:0]         out_mode
);

  localparam int unsigned N = WIDTH / LEAF_W;

  logic             advance;
  logic [WIDTH-1:0] a1, b1;
  mode_e            mode1, mode2;
  logic             v1, v2;
  logic [LEAF_P-1:0] p_leaf [N][N];
  logic [LEAF_P-1:0] p2     [N][N];
  logic [2*WIDTH-1:0] sum;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // S1: operand capture; bubbles are captured too and tracked by v1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1    <= '0;
      b1    <= '0;
      mode1 <= MODE_EXACT;
      v1    <= 1'b0;
    end else if (advance) begin
      a1    <= a;
      b1    <= b;
      mode1 <= norm_mode(mode);
      v1    <= in_valid;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic en;
      assign en = leaf_approx_en(gi, gj, mode1, WIDTH);
      approx_mult4x4_leaf u_leaf (
        .a         (a1[gi*LEAF_W +: LEAF_W]),
        .b         (b1[gj*LEAF_W +: LEAF_W]),
        .approx_en (en),
        .p         (p_leaf[gi][gj])
      );
    end
  end

  // S2: register the leaf product grid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          p2[i][j] <= '0;
        end
      end
      mode2 <= MODE_EXACT;
      v2    <= 1'b0;
    end else if (advance) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          p2[i][j] <= p_leaf[i][j];
        end
      end
      mode2 <= mode1;
      v2    <= v1;
    end
  end

  // Recombine leaves at their nibble weights; full width so no carry is lost.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        sum = sum + ((2*WIDTH)'(p2[i][j]) << (LEAF_W * (i + j)));
      end
    end
  end

  // S3: result register; a bubble leaves y and out_mode at their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y         <= '0;
      out_mode  <= '0;
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= v2;
      if (v2) begin
        y        <= sum;
        out_mode <= mode2;
      end
    end
  end

endmodule

// File: doc/approx_recursive_mult_pipe.md
Name: approx_recursive_mult_pipe

Overview:
- Parametrised, pipelined recursive unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Built from 4x4 leaf multipliers; each leaf runs exact or approximate, selected per transaction by a mode field.
- Sits between operand sources and accumulators in the low-power datapath.
- Valid/ready on both sides, throughput one product per cycle, global stall on backpressure.

Parameters:
- WIDTH, 8, operand width; legal values 8 and 16 (leaf grid N = WIDTH/4 per side).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand transaction valid.
- in_ready  output  1  block can accept this cycle.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- mode  input  2  0 = EXACT, 1 = LOW (approximate low-weight leaves only), 2 = ALL (every leaf approximate), 3 = reserved, treated as EXACT.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- y  output  2*WIDTH  product.
- out_mode  output  2  mode of the presented result, after the 3 -> 0 mapping.

Behaviour:
- Reset is asynchronous on rst high; it clears all stage valid bits and data registers. Outputs during and after reset: out_valid=0, y=0, out_mode=0. A transaction in flight at reset is discarded, not completed.
- advance = !out_valid | out_ready. All three stage registers load only when advance=1. in_ready = advance, a combinational function of out_valid and out_ready only. Bubbles are not collapsed.
- Stage S1: on advance, capture a, b, mode and v1 = in_valid.
- Stage S2: compute the N*N leaf products P[i][j] = leaf(a nibble i, b nibble j, approx_en[i][j]), each 8 bits, and register them with v2 and the mode.
- Stage S3: y = sum over i,j of P[i][j] << 4*(i+j), computed at full 2*WIDTH width with no truncation and no overflow possible. Register y, out_mode, and out_valid = v2.
- Latency: accepted on edge T -> out_valid=1 and y valid from edge T+2. Back-to-back inputs give back-to-back outputs.
- When out_valid=1 and out_ready=0, y, out_mode and every stage hold unchanged and in_ready=0.
- A transaction accepted while in_valid=0 (a bubble) propagates as a bubble; S3 then keeps y at its last value, with out_valid=0.
- approx_en[i][j]:
  - EXACT: 0 for every leaf.
  - ALL: 1 for every leaf.
  - LOW: 1 only when 4*(i+j) < WIDTH/2. For WIDTH=8 this is the LL leaf only; for WIDTH=16 it is the leaves at shift 0 and 4.
- Exact leaf: 8-bit product a4*b4.
- Approximate leaf: with pXY = a[X]&b[Y], the output bits are:
  - y0 = p00.
  - s1 = p01^p10, c1 = p01&p10.
  - P20 = p20|p02, G20 = p20&p02. s2 = P20|p11, c2 = G20|c1.
  - G3 = (p30&p03)|(p21&p12), P21 = p21|p12, P30 = p30|p03. s3 = c2|P21|P30, c3 = (c2&G3)|(P21&P30).
  - P31 = p31|p13, G31 = p31&p13. s4 = P31|p22, c4 = G31|(p22&c3).
  - Column 5: full add of p32, p23, c4 -> s5, c5.
  - Column 6: half add of p33, c5 -> s6, c6.
  - Result = {c6, s6, s5, s4, s3, s2, s1, y0}.

Decomposition:
- Package approx_mult_pkg holds:
  - the mode constants MODE_EXACT=0, MODE_LOW=1, MODE_ALL=2;
  - LEAF_W=4;
  - a function mapping (i, j, mode, WIDTH) -> approx_en.
- One sub-module, approx_mult4x4_leaf: combinational, with inputs a[3:0], b[3:0], approx_en and output p[7:0]. It implements both the exact and the approximate equations.
- The top level instantiates N*N leaves through a generate loop and owns the pipeline and handshake.

Test Plan:
- WIDTH=8, out_ready=1: a=0x03, b=0x03 in modes 0, 1, 2 -> y=9, 13, 13, each two edges after acceptance.
- WIDTH=8: a=0xFF, b=0xFF in modes 0, 1, 2, 3 -> y=0xFE01 (65025), 64989, 0xD55D (54621), 65025 with out_mode=0.
- Backpressure: stream 4 transactions, hold out_ready=0 for 5 cycles while out_valid=1 -> in_ready=0, y is stable, no loss or duplication, in-order completion once out_ready rises.
- Reset mid-stream: assert rst with 2 transactions in flight -> out_valid=0 and y=0 immediately; nothing from the pre-reset transactions is emitted after release.
- Random 10k vectors, both WIDTH values, random in_valid and out_ready -> every y matches a reference model built from the leaf equations; y equals the exact product in mode 0.
- WIDTH=16, mode 1, a=0x0003, b=0x0003 -> y=13; a=0x0300, b=0x0003 -> y=0x0900 (exact leaf at shift 8).
